trng_collector: RTL and testbench

Parametrised entropy collector behind the ring-oscillator TRNG array. It gates the oscillators and samples their raw output bit at a programmable rate. After a warm-up it applies optional von Neumann debiasing, packs accepted bits into WIDTH-bit words, and presents each word on a valid/ready port. A repetition-count health test stops output and latches a fault if the raw source sticks.

---
 rtl/trng_collector.sv | 156 +++++++++++++++
 tb/tb_trng_collector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_collector.sv
// trng_collector: ring-oscillator sampler with warm-up, health test and word packer.
// Define TRNG_VON_NEUMANN_EN to debias tick samples before packing.
module trng_collector #(
  parameter int WIDTH      = 32,
  parameter int SAMPLE_DIV = 4,
  parameter int WARMUP     = 64,
  parameter int REP_LIMIT  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             raw_in,
  output logic             trng_en,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             health_fail_o
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WARM, S_COLL, S_FULL, S_FAIL
  } state_t;

  state_t            state;
  logic [1:0]        sync;
  logic [DW-1:0]     div_cnt;
  logic [WW-1:0]     warm_cnt;
  logic [RW-1:0]     rep_cnt;
  logic [RW-1:0]     rep_nxt;
  logic [BW-1:0]     bit_cnt;
  logic [WIDTH-2:0]  shreg;
  logic [WIDTH-1:0]  word_nxt;
  logic              prev;
  logic              sample;
  logic              tick;
  logic              trip;
  logic              acc;
  logic              acc_bit;

  assign sample = sync[1];
  assign tick = (state == S_WARM || state == S_COLL)
             && (div_cnt == DW'(SAMPLE_DIV - 1));

  // rep_cnt == 0 marks "no sample seen since WARMUP entry"
  always_comb begin
    rep_nxt = RW'(1);
    if (rep_cnt != '0 && sample == prev) rep_nxt = rep_cnt + 1'b1;
  end

  assign trip = tick && (rep_nxt == RW'(REP_LIMIT));
  assign word_nxt = {shreg, acc_bit};

`ifdef TRNG_VON_NEUMANN_EN
  logic pair_ph;
  logic pair_bit;

  assign acc = tick && state == S_COLL && pair_ph && (pair_bit != sample);
  assign acc_bit = pair_bit;

  always_ff @(posedge clk) begin
    if (!rst_n || state != S_COLL) begin
      pair_ph  <= 1'b0;
      pair_bit <= 1'b0;
    end else if (tick) begin
      pair_ph <= ~pair_ph;
      if (!pair_ph) pair_bit <= sample;
    end
  end
`else
  assign acc = tick && state == S_COLL;
  assign acc_bit = sample;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      sync          <= '0;
      div_cnt       <= '0;
      warm_cnt      <= '0;
      rep_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      prev          <= 1'b0;
      trng_en       <= 1'b0;
      data_o        <= '0;
      valid_o       <= 1'b0;
      health_fail_o <= 1'b0;
    end else begin
      sync <= {sync[0], raw_in};
      if (!enable) begin
        state         <= S_IDLE;
        div_cnt       <= '0;
        warm_cnt      <= '0;
        rep_cnt       <= '0;
        bit_cnt       <= '0;
        shreg         <= '0;
        prev          <= 1'b0;
        trng_en       <= 1'b0;
        valid_o       <= 1'b0;
        health_fail_o <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            state   <= (WARMUP == 0) ? S_COLL : S_WARM;
            trng_en <= 1'b1;
            div_cnt <= '0;
          end
          S_WARM, S_COLL: begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
              rep_cnt <= rep_nxt;
              prev    <= sample;
            end
            // a trip wins over word completion on the same tick
            if (trip) begin
              state         <= S_FAIL;
              trng_en       <= 1'b0;
              health_fail_o <= 1'b1;
            end else if (tick && state == S_WARM) begin
              if (warm_cnt == WW'(WARMUP - 1)) state <= S_COLL;
              else warm_cnt <= warm_cnt + 1'b1;
            end else if (acc) begin
              shreg <= word_nxt[WIDTH-2:0];
              if (bit_cnt == BW'(WIDTH - 1)) begin
                data_o  <= word_nxt;
                valid_o <= 1'b1;
                bit_cnt <= '0;
                state   <= S_FULL;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          S_FULL: begin
            div_cnt <= '0;
            if (ready_i) begin
              valid_o <= 1'b0;
              state   <= S_COLL;
            end
          end
          S_FAIL: begin
            trng_en <= 1'b0;
            valid_o <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: two collectors (divider 1 and 4) against a tick-level model.
// Raw streams are pre-generated so the model can predict each word ahead of time.
module tb_trng_collector;

  localparam int W  = 8;
  localparam int NW = 4;
  localparam int RL = 8;
  localparam int N  = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en [2];
  logic raw [2];
  logic rdy [2];
  logic ten [2];
  logic vld [2];
  logic hf [2];
  logic [W-1:0] dat [2];

  bit st [2][N];
  int t = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int hrep [2];
  bit hprev [2];
  bit hfirst [2];

  always #5 clk = ~clk;

  trng_collector #(
    .WIDTH(W), .SAMPLE_DIV(1), .WARMUP(NW), .REP_LIMIT(RL)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .raw_in(raw[0]),
    .trng_en(ten[0]), .data_o(dat[0]), .valid_o(vld[0]),
    .ready_i(rdy[0]), .health_fail_o(hf[0])
  );

  trng_collector #(
    .WIDTH(W), .SAMPLE_DIV(4), .WARMUP(NW), .REP_LIMIT(RL)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .raw_in(raw[1]),
    .trng_en(ten[1]), .data_o(dat[1]), .valid_o(vld[1]),
    .ready_i(rdy[1]), .health_fail_o(hf[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // edge number t sees raw = st[d][t]
  task automatic cycle();
    raw[0] = st[0][t];
    raw[1] = st[1][t];
    @(posedge clk);
    t++;
    #1;
  endtask

  // Walk the ticks from entry edge s: nw warm-up ticks, then packing.
  // Returns the edge of the completing (or tripping) tick.
  function automatic void model(input int d, input int s, input int nw,
                                output logic [W-1:0] w, output int te,
                                output bit tr);
    bit smp;
    bit fb;
    bit have;
    int nb;
    int tt;
    w = '0; te = 0; tr = 1'b0; nb = 0; have = 1'b0; fb = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      tt = s + k * (d == 1 ? 4 : 1);
      if (tt >= N) break;
      smp = st[d][tt-2];
      if (hfirst[d] || smp != hprev[d]) hrep[d] = 1;
      else hrep[d] = hrep[d] + 1;
      hfirst[d] = 1'b0;
      hprev[d] = smp;
      if (hrep[d] >= RL) begin
        tr = 1'b1;
        te = tt;
        return;
      end
      if (k > nw) begin
`ifdef TRNG_VON_NEUMANN_EN
        if (!have) begin
          have = 1'b1;
          fb = smp;
        end else begin
          have = 1'b0;
          if (fb != smp) begin
            w = {w[W-2:0], fb};
            nb++;
          end
        end
`else
        w = {w[W-2:0], smp};
        nb++;
`endif
        if (nb == W) begin
          te = tt;
          return;
        end
      end
    end
  endfunction

  task automatic start(input int d, output int e0);
    en[d] = 1'b1;
    e0 = t;
    hfirst[d] = 1'b1;
    cycle();
    chk("trng_en_on", 32'(ten[d]), 32'd1);
    chk("fault_clear", 32'(hf[d]), 32'd0);
  endtask

  task automatic run_seg(input int d, input int s, input int nw,
                         output bit ok, output logic [W-1:0] w);
    int te;
    bit tr;
    model(d, s, nw, w, te, tr);
    while (t < te) begin
      rdy[d] = 1'($urandom);
      cycle();
    end
    chk("pre_valid", 32'(vld[d]), 32'd0);
    chk("pre_fault", 32'(hf[d]), 32'd0);
    cycle();
    rdy[d] = 1'b0;
    if (tr) begin
      chk("fault_rise", 32'(hf[d]), 32'd1);
      chk("fault_ten", 32'(ten[d]), 32'd0);
      chk("fault_vld", 32'(vld[d]), 32'd0);
    end else begin
      chk("valid_rise", 32'(vld[d]), 32'd1);
      chk("word", 32'(dat[d]), 32'(w));
    end
    ok = !tr;
  endtask

  task automatic handshake(input int d, input int hold,
                           input logic [W-1:0] w, output int h);
    repeat (hold) cycle();
    chk("valid_held", 32'(vld[d]), 32'd1);
    chk("data_held", 32'(dat[d]), 32'(w));
    rdy[d] = 1'b1;
    h = t;
    cycle();
    rdy[d] = 1'b0;
    chk("valid_drop", 32'(vld[d]), 32'd0);
  endtask

  task automatic words(input int d, input int n);
    bit ok;
    logic [W-1:0] w;
    int e0;
    int h;
    e0 = t;
    start(d, e0);
    run_seg(d, e0, NW, ok, w);
    for (int i = 0; i < n; i++) begin
      if (ok) begin
        handshake(d, $urandom_range(0, 5), w, h);
        run_seg(d, h, 0, ok, w);
      end else begin
        en[d] = 1'b0;
        cycle();
        chk("abort_fault", 32'(hf[d]), 32'd0);
        start(d, e0);
        run_seg(d, e0, NW, ok, w);
      end
    end
    en[d] = 1'b0;
    cycle();
  endtask

`ifdef TRNG_VON_NEUMANN_EN
  localparam int DL = 24;
  localparam logic [DL-1:0] DV = {4'b0101, 20'b10010011101001011001};
`else
  localparam int DL = 12;
  localparam logic [DL-1:0] DV = {4'b0101, 8'b10110010};
`endif

  initial begin
    bit ok;
    logic [W-1:0] w;
    logic [DL-1:0] dv;
    int e;
    int e0;
    int h;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0;
      raw[d] = 1'b0;
      rdy[d] = 1'b0;
      hrep[d] = 0;
      hprev[d] = 1'b0;
      hfirst[d] = 1'b1;
      for (int i = 0; i < N; i++) st[d][i] = 1'($urandom);
    end

    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (20) cycle();
    for (int d = 0; d < 2; d++) begin
      chk("rst_trng_en", 32'(ten[d]), 32'd0);
      chk("rst_valid", 32'(vld[d]), 32'd0);
      chk("rst_data", 32'(dat[d]), 32'd0);
      chk("rst_fault", 32'(hf[d]), 32'd0);
    end

    // directed word on the divide-by-1 collector
    dv = DV;
    e = t + 3;
    for (int k = 1; k <= DL; k++) st[0][e+k-2] = dv[DL-k];
    while (t < e) cycle();
    start(0, e0);
    run_seg(0, e0, NW, ok, w);
`ifndef TRNG_VON_NEUMANN_EN
    chk("word_b2", 32'(dat[0]), 32'h0000_00B2);
`endif
    rdy[0] = 1'b1;
    cycle();
    rdy[0] = 1'b0;
    chk("full_ignores_prev", 32'(vld[0]), 32'd0);
    run_seg(0, t - 1, 0, ok, w);
    handshake(0, 10, w, h);
    en[0] = 1'b0;
    cycle();

    // stuck-at-1 source trips the health test
    e = t + 3;
    for (int i = e - 2; i < e + 12; i++) st[0][i] = 1'b1;
    while (t < e) cycle();
    start(0, e0);
    run_seg(0, e0, NW, ok, w);
    repeat (5) cycle();
    chk("fail_sticky", 32'(hf[0]), 32'd1);
    chk("fail_ten_low", 32'(ten[0]), 32'd0);
    chk("fail_no_valid", 32'(vld[0]), 32'd0);
    en[0] = 1'b0;
    cycle();
    chk("idle_clears_fault", 32'(hf[0]), 32'd0);
    chk("idle_ten", 32'(ten[0]), 32'd0);
    start(0, e0);
    run_seg(0, e0, NW, ok, w);
    en[0] = 1'b0;
    cycle();

    // divide-by-4: abort mid-word, then a clean run
    for (int i = t; i < t + 80; i++) st[1][i] = 1'(i % 2);
    start(1, e0);
    repeat (30) cycle();
    chk("midword_valid", 32'(vld[1]), 32'd0);
    chk("midword_ten", 32'(ten[1]), 32'd1);
    en[1] = 1'b0;
    cycle();
    chk("abort_ten", 32'(ten[1]), 32'd0);
    chk("abort_valid", 32'(vld[1]), 32'd0);
    repeat (2) cycle();
    start(1, e0);
    run_seg(1, e0, NW, ok, w);
    en[1] = 1'b0;
    cycle();

    // randomized streams with random consumer back-pressure
    words(0, 8);
    words(1, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
